// File: rtl/keypad_pkg.sv
// Shared types and key codes for the 4x4 keypad number-entry block.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [3:0] KEY_BKSP  = 4'd10;
    localparam logic [3:0] KEY_CLR   = 4'd12;
    localparam logic [3:0] KEY_ENTER = 4'd15;
    localparam int         NUM_MAX   = 9999;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_col_decode.sv
// Maps the active row index and sensed columns to a key code.
module keypad_col_decode
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [3:0] col,
    output logic       valid,
    output logic [3:0] code
);

    logic [1:0] col_idx;

    always_comb begin
        valid   = 1'b1;
        col_idx = 2'd0;
        unique case (col)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: valid   = 1'b0;
        endcase
    end

    assign code = {row_idx, col_idx};

endmodule

// File: rtl/keypad_num_entry.sv
// Scanned 4x4 keypad with debounce and decimal entry up to 9999.
// Define KEYPAD_SIM_FASTSCAN_EN for a 2-cycle dwell period in simulation.
module keypad_num_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 32000,
    parameter int DEBOUNCE_DWELLS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    output logic [31:0] num,
    output logic [31:0] entered,
    output logic        entered_valid,
    output logic        overflow
);

`ifdef KEYPAD_SIM_FASTSCAN_EN
    localparam int DWELL = 2;
`else
    localparam int DWELL = SCAN_DIV;
`endif
    localparam int CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_DWELLS + 1);
    localparam bit DB_ONE = (DEBOUNCE_DWELLS <= 1);
    localparam logic [DB_W-1:0] DB_END = DB_W'(DEBOUNCE_DWELLS - 1);

    logic [CW-1:0]   div_q;
    logic            sample;
    state_t          state_q, state_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [3:0]      cap_col_q, cap_col_d;
    logic [3:0]      cap_code_q, cap_code_d;
    logic            act_q, act_d;
    logic [3:0]      act_code_q, act_code_d;
    logic [13:0]     num_q, num_d;
    logic [13:0]     ent_q, ent_d;
    logic            ev_q, ev_d;
    logic            ov_q, ov_d;
    logic            key_valid;
    logic [3:0]      key_code;
    logic [17:0]     prod;

    keypad_col_decode u_dec (
        .row_idx (row_idx_q),
        .col     (col),
        .valid   (key_valid),
        .code    (key_code)
    );

    assign sample = (div_q == CW'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            state_q    <= IDLE;
            row_idx_q  <= 2'd0;
            db_q       <= '0;
            cap_col_q  <= 4'hF;
            cap_code_q <= 4'd0;
            act_q      <= 1'b0;
            act_code_q <= 4'd0;
            num_q      <= '0;
            ent_q      <= '0;
            ev_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            div_q      <= sample ? '0 : div_q + 1'b1;
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            db_q       <= db_d;
            cap_col_q  <= cap_col_d;
            cap_code_q <= cap_code_d;
            act_q      <= act_d;
            act_code_q <= act_code_d;
            num_q      <= num_d;
            ent_q      <= ent_d;
            ev_q       <= ev_d;
            ov_q       <= ov_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        db_d       = db_q;
        cap_col_d  = cap_col_q;
        cap_code_d = cap_code_q;
        act_d      = 1'b0;
        act_code_d = act_code_q;
        if (sample) begin
            unique case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        cap_col_d  = col;
                        cap_code_d = key_code;
                        if (DB_ONE) begin
                            act_d      = 1'b1;
                            act_code_d = key_code;
                            state_d    = HELD;
                            db_d       = '0;
                        end else begin
                            state_d = PRESS_DB;
                            db_d    = DB_W'(1);
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                PRESS_DB: begin
                    if (col != cap_col_q) begin
                        state_d = IDLE;
                        db_d    = '0;
                    end else if (db_q == DB_END) begin
                        act_d      = 1'b1;
                        act_code_d = cap_code_q;
                        state_d    = HELD;
                        db_d       = '0;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
                HELD: begin
                    if (col == 4'hF) begin
                        if (DB_ONE) begin
                            state_d   = IDLE;
                            row_idx_d = row_idx_q + 2'd1;
                        end else begin
                            state_d = RELEASE_DB;
                            db_d    = DB_W'(1);
                        end
                    end
                end
                RELEASE_DB: begin
                    if (col != 4'hF) begin
                        state_d = HELD;
                        db_d    = '0;
                    end else if (db_q == DB_END) begin
                        state_d   = IDLE;
                        db_d      = '0;
                        row_idx_d = row_idx_q + 2'd1;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Key action is applied one cycle after the accepting sample.
    assign prod = {4'd0, num_q} * 18'd10 + {14'd0, act_code_q};

    always_comb begin
        num_d = num_q;
        ent_d = ent_q;
        ev_d  = 1'b0;
        ov_d  = 1'b0;
        if (act_q) begin
            unique case (1'b1)
                (act_code_q <= 4'd9): begin
                    if (prod <= 18'(NUM_MAX))
                        num_d = prod[13:0];
                    else
                        ov_d = 1'b1;
                end
                (act_code_q == KEY_BKSP):  num_d = num_q / 14'd10;
                (act_code_q == KEY_CLR):   num_d = '0;
                (act_code_q == KEY_ENTER): begin
                    ent_d = num_q;
                    ev_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign row           = row_drive(row_idx_q);
    assign num           = {18'd0, num_q};
    assign entered       = {18'd0, ent_q};
    assign entered_valid = ev_q;
    assign overflow      = ov_q;

endmodule

// File: tb/tb_keypad_num_entry.sv
// Self-checking bench: a keypad matrix model drives col from row.
module tb_keypad_num_entry;

    localparam int DW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] num;
    logic [31:0] entered;
    logic        entered_valid;
    logic        overflow;

    logic [15:0] pressed   = 16'h0;
    logic [3:0]  force_low = 4'h0;

    int n_chk  = 0;
    int n_fail = 0;
    int ev_cnt = 0, ov_cnt = 0;
    int ev_long = 0, ov_long = 0, row_bad = 0;
    logic ev_prev = 1'b0, ov_prev = 1'b0;

    int m_num = 0;
    int m_ent = 0;

    keypad_num_entry #(
        .SCAN_DIV        (2),
        .DEBOUNCE_DWELLS (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row           (row),
        .col           (col),
        .num           (num),
        .entered       (entered),
        .entered_valid (entered_valid),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key shorts its row line onto its column line.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r])
                    col[c] = 1'b0;
        col = col & ~force_low;
    end

    always @(negedge clk) begin
        if (entered_valid) ev_cnt++;
        if (overflow) ov_cnt++;
        if (entered_valid && ev_prev) ev_long++;
        if (overflow && ov_prev) ov_long++;
        if ($countones(~row) != 1) row_bad++;
        ev_prev = entered_valid;
        ov_prev = overflow;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: decimal entry semantics applied per key press.
    task automatic model_key(input int k, output int exp_ov, output int exp_ev);
        exp_ov = 0;
        exp_ev = 0;
        if (k <= 9) begin
            if (m_num * 10 + k <= 9999) m_num = m_num * 10 + k;
            else exp_ov = 1;
        end else if (k == 10) begin
            m_num = m_num / 10;
        end else if (k == 12) begin
            m_num = 0;
        end else if (k == 15) begin
            m_ent = m_num;
            exp_ev = 1;
        end
    endtask

    task automatic press(input int k, input int hold_d, input int rel_d, input string tag);
        int ov0, ev0, eov, eev;
        ov0 = ov_cnt;
        ev0 = ev_cnt;
        @(negedge clk);
        pressed = 16'h1 << k;
        repeat (hold_d * DW) @(negedge clk);
        pressed = 16'h0;
        repeat (rel_d * DW) @(negedge clk);
        model_key(k, eov, eev);
        check({tag, "_num"}, num, m_num);
        check({tag, "_entered"}, entered, m_ent);
        check({tag, "_ovf"}, ov_cnt - ov0, eov);
        check({tag, "_ev"}, ev_cnt - ev0, eev);
    endtask

    task automatic scan_seen(input string tag);
        logic [3:0] seen;
        seen = 4'h0;
        repeat (10 * DW) begin
            @(negedge clk);
            for (int r = 0; r < 4; r++)
                if (!row[r]) seen[r] = 1'b1;
        end
        check(tag, seen, 4'hF);
    endtask

    initial begin
        int ov0, ev0;
        repeat (3) @(negedge clk);
        check("rst_row", row, 4'b1110);
        check("rst_num", num, 0);
        check("rst_entered", entered, 0);
        check("rst_ev", entered_valid, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;

        press(1, 12, 12, "k1");
        press(2, 12, 12, "k2");
        press(3, 12, 12, "k3");
        press(4, 12, 12, "k4");
        check("num_1234", num, 1234);
        press(5, 12, 12, "ovf5");
        press(10, 12, 12, "bksp");
        check("num_123", num, 123);
        press(12, 12, 12, "clr");
        press(10, 12, 12, "bksp0");
        press(12, 12, 12, "clr0");
        check("num_zero", num, 0);

        ov0 = ov_cnt;
        ev0 = ev_cnt;
        @(negedge clk);
        force_low = 4'b0001;
        repeat (2 * DW) @(negedge clk);
        force_low = 4'b0000;
        repeat (4 * DW) @(negedge clk);
        check("bounce_num", num, m_num);
        scan_seen("bounce_scan");

        force_low = 4'b0011;
        repeat (4 * DW) @(negedge clk);
        scan_seen("multi_scan");
        force_low = 4'b0000;
        repeat (6 * DW) @(negedge clk);
        check("multi_num", num, m_num);
        check("noise_ovf", ov_cnt - ov0, 0);
        check("noise_ev", ev_cnt - ev0, 0);

        for (int i = 0; i < 40; i++)
            press($urandom_range(0, 15), $urandom_range(9, 14),
                  $urandom_range(6, 12), "rnd");

        press(12, 12, 12, "pre_clr");
        press(4, 12, 12, "pre_4");
        press(2, 12, 12, "pre_2");
        press(15, 12, 12, "enter42");
        check("enter_val", entered, 42);
        check("enter_num", num, 42);

        @(negedge clk);
        pressed = 16'h1 << 7;
        repeat (12 * DW) @(negedge clk);
        check("held7_num", num, 427);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_num", num, 0);
        check("mid_rst_entered", entered, 0);
        check("mid_rst_row", row, 4'b1110);
        check("mid_rst_ev", entered_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        repeat (12 * DW) @(negedge clk);
        pressed = 16'h0;
        repeat (12 * DW) @(negedge clk);
        check("reaccept7", num, 7);
        check("reaccept_ent", entered, 0);

        check("ev_width", ev_long, 0);
        check("ovf_width", ov_long, 0);
        check("row_onehot", row_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_num_entry.md
KEYPAD_NUM_ENTRY -- requirements
Module: keypad_num_entry

Interface
REQ-001 Parameter SCAN_DIV, default 32000, clk cycles each row is driven (dwell period).
REQ-002 Parameter DEBOUNCE_DWELLS, default 4, consecutive identical dwell samples needed to accept a press or a release.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 row  output  4  keypad row drive, active-low, exactly one bit low at a time.
REQ-006 col  input  4  keypad column sense, active-low, externally pulled up.
REQ-007 num  output  32 (int)  live entry value, 0..9999, intended to feed the 7-segment display driver.
REQ-008 entered  output  32 (int)  value latched at the last ENTER key.
REQ-009 entered_valid  output  1  one-cycle pulse when entered updates.
REQ-010 overflow  output  1  one-cycle pulse when a digit is rejected because the result would exceed 9999.

Function
REQ-011 Dwell counter SHALL count 0..SCAN_DIV-1; col SHALL be sampled only on count SCAN_DIV-1, which gives settle time.
REQ-012 In IDLE, row SHALL advance 1110->1101->1011->0111->1110 after each sample with col==1111.
REQ-013 A sample with exactly one col bit low SHALL be a candidate key: code = 4*row_index + col_index (0..15), with row_index 0 for row==1110 and col_index 0 for col[0].
REQ-014 A sample with two or more col bits low SHALL be treated as no key.
REQ-015 States: IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-016 IDLE -> PRESS_DB on a candidate key: row scanning freezes and the code is captured.
REQ-017 In PRESS_DB, a sample differing from the captured col SHALL return the FSM to IDLE.
REQ-018 In PRESS_DB, DEBOUNCE_DWELLS matching samples in total (including the first) SHALL trigger the key action and a transition to HELD.
REQ-019 HELD -> RELEASE_DB on a sample with col==1111; no further action while the key is held.
REQ-020 In RELEASE_DB, any low col SHALL return the FSM to HELD.
REQ-021 In RELEASE_DB, DEBOUNCE_DWELLS consecutive 1111 samples SHALL send the FSM to IDLE; scanning resumes at the next row.
REQ-022 Key action, codes 0-9: if num*10+code <= 9999, then num <= num*10+code; otherwise num is unchanged and overflow pulses.
REQ-023 Key action, code 10 (backspace): num <= num/10.
REQ-024 Key action, code 12 (clear): num <= 0.
REQ-025 Key action, code 15 (enter): entered <= num and entered_valid pulses; num is unchanged.
REQ-026 Key action, codes 11, 13, 14: no effect.
REQ-027 Every key action SHALL take effect one cycle after the accepting sample.
REQ-028 Pulse outputs SHALL be low on all other cycles.
REQ-029 Backspace at 0 SHALL leave num at 0; clear at 0 SHALL leave num at 0.

Reset
REQ-030 While rst is high at a clk edge, all outputs and state SHALL take reset values:
- row=1110
- num=0, entered=0
- entered_valid=0, overflow=0
- state IDLE, all counters 0
REQ-031 rst asserted mid-debounce or while a key is held SHALL abort with no key action.
REQ-032 After rst, a still-held key SHALL be treated as a new press.

Configuration
REQ-033 Macro KEYPAD_SIM_FASTSCAN_EN: when defined, the dwell period SHALL be 2 cycles, ignoring SCAN_DIV; when undefined, the dwell period SHALL be SCAN_DIV cycles.

Structure
REQ-034 Package keypad_pkg SHALL hold the state enum, KEY_BKSP=10, KEY_CLR=12, KEY_ENTER=15 and NUM_MAX=9999.
REQ-035 Sub-module keypad_col_decode SHALL combinationally map (row_index, col) to {valid, code[3:0]}, with valid=0 for zero or multiple low bits.

Verification (KEYPAD_SIM_FASTSCAN_EN defined, DEBOUNCE_DWELLS=4)
REQ-036 Press keys 1,2,3,4 in sequence, each held 12 dwells then released 12 dwells -> num=1234, no overflow.
REQ-037 From num=1234, press 5 -> num stays 1234 and overflow pulses once.
REQ-038 From num=1234: press backspace -> num=123; press clear -> num=0; press backspace again -> num=0.
REQ-039 num=42, press enter -> entered=42 with a one-cycle entered_valid pulse, and num stays 42.
REQ-040 Col bounces low for 2 dwells, then goes high -> no action and scanning resumes.
REQ-041 Two cols low simultaneously -> ignored.
REQ-042 Key 7 held, rst pulsed for one cycle -> all outputs take reset values; after rst release, key 7 is re-accepted and num=7.
